// File: rtl/mining_pkg.sv
// Shared types for the nonce search block: nonce width and job FSM states.
package mining_pkg;

  localparam int NONCE_W = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

endpackage

// File: rtl/inflight_counter.sv
// Up/down count of hashes outstanding in the core; saturates at MAX_INFLIGHT
// and refuses to go below zero, flagging a decrement at zero as underflow_err.
module inflight_counter #(
  parameter  int MAX_INFLIGHT = 64,
  localparam int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             zero,
  output logic             full,
  output logic             underflow_err
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             inc_ok;
  logic             dec_ok;

  assign zero          = (count_q == '0);
  assign full          = (count_q == CNT_W'(MAX_INFLIGHT));
  assign underflow_err = dec & zero;
  assign inc_ok        = inc & ~full;
  assign dec_ok        = dec & ~zero;
  assign count         = count_q;

  always_comb begin
    count_d = count_q;
    if (inc_ok && !dec_ok) begin
      count_d = count_q + CNT_W'(1);
    end else if (dec_ok && !inc_ok) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/nonce_scheduler.sv
// Issues nonces start..end in order to a pipelined hash core, stops on first hit,
// exhaustion or abort, drains outstanding hashes, then holds the result in DONE.
module nonce_scheduler #(
  parameter  int NONCE_W      = mining_pkg::NONCE_W,
  parameter  int MAX_INFLIGHT = 64,
  localparam int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               abort,
  input  logic [NONCE_W-1:0] range_start,
  input  logic [NONCE_W-1:0] range_end,
  output logic               issue_valid,
  input  logic               issue_ready,
  output logic [NONCE_W-1:0] issue_nonce,
  input  logic               result_valid,
  input  logic               result_hit,
  input  logic [NONCE_W-1:0] result_nonce,
  output logic               busy,
  output logic               done,
  output logic               found,
  output logic [NONCE_W-1:0] found_nonce,
  output logic               aborted,
  output logic               proto_err
);
  import mining_pkg::*;

  state_e             state_q;
  logic [NONCE_W-1:0] cur_q;
  logic [NONCE_W-1:0] end_q;
  logic [NONCE_W-1:0] found_nonce_q;
  logic               found_q;
  logic               aborted_q;
  logic               proto_err_q;

  logic [CNT_W-1:0]   count;
  logic               cnt_zero;
  logic               cnt_full;
  logic               underflow_err;
  logic               fire;
  logic               hit;
  logic               at_end;
  logic               drain_empty;

  inflight_counter #(
    .MAX_INFLIGHT(MAX_INFLIGHT)
  ) u_inflight (
    .clk          (clk),
    .reset_n      (reset_n),
    .inc          (fire),
    .dec          (result_valid),
    .count        (count),
    .zero         (cnt_zero),
    .full         (cnt_full),
    .underflow_err(underflow_err)
  );

  // abort gates issue combinationally so a same-cycle fire can never happen
  assign issue_valid = (state_q == S_RUN) & ~cnt_full & ~abort;
  assign issue_nonce = cur_q;
  assign fire        = issue_valid & issue_ready;
  assign hit         = result_valid & result_hit;
  assign at_end      = (cur_q == end_q);
  assign drain_empty = cnt_zero | ((count == CNT_W'(1)) & result_valid);

  assign busy        = (state_q == S_RUN) | (state_q == S_DRAIN);
  assign done        = (state_q == S_DONE);
  assign found       = found_q;
  assign found_nonce = found_nonce_q;
  assign aborted     = aborted_q;
  assign proto_err   = proto_err_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      cur_q         <= '0;
      end_q         <= '0;
      found_q       <= 1'b0;
      found_nonce_q <= '0;
      aborted_q     <= 1'b0;
      proto_err_q   <= 1'b0;
    end else begin
      proto_err_q <= proto_err_q | underflow_err;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            cur_q         <= range_start;
            end_q         <= range_end;
            found_q       <= 1'b0;
            found_nonce_q <= '0;
            aborted_q     <= 1'b0;
            state_q       <= (range_start > range_end) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          // cur holds at the last nonce so an all-ones end never wraps
          if (fire && !at_end) begin
            cur_q <= cur_q + NONCE_W'(1);
          end
          if (hit) begin
            found_q       <= 1'b1;
            found_nonce_q <= result_nonce;
          end
          if (abort) begin
            aborted_q <= 1'b1;
          end
          if (abort || hit || (fire && at_end)) begin
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (hit && !found_q) begin
            found_q       <= 1'b1;
            found_nonce_q <= result_nonce;
          end
          if (abort) begin
            aborted_q <= 1'b1;
          end
          if (drain_empty) begin
            state_q <= S_DONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
